// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO plus drain controller that sits between the MMIO store path for
// the UART TX register and the uart_tx serialiser. Stores that arrive while
// the serialiser is busy are queued rather than lost, and queued bytes are
// launched one at a time over uart_tx's tx_start / tx_busy / tx_done
// handshake. Occupancy and a sticky overflow flag are exported so software
// can poll them through the MMIO status path.
//
// Parameters
//   DEPTH    number of FIFO entries (power of two, >= 2)
//   DATA_W   byte width, must match uart_tx tx_data
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   wr_en     in   MMIO store to the UART TX register this cycle
//   wr_data   in   byte to queue
//   ovf_clr   in   clears the sticky overflow flag
//   tx_busy   in   serialiser busy, from uart_tx
//   tx_done   in   one-cycle end-of-frame pulse, from uart_tx
//   tx_start  out  one-cycle launch pulse to uart_tx
//   tx_data   out  byte to uart_tx, held from launch until the next launch
//   count     out  entries currently queued, 0..DEPTH
//   full      out  count == DEPTH
//   empty     out  count == 0
//   overflow  out  sticky: a store arrived while the FIFO was full
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     ovf_clr,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  // Storage is plain data: it is never reset, only the pointers and count
  // decide which entries are meaningful.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              overflow_q, overflow_d;
  state_t            state_q,    state_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q,  tx_data_d;

  logic full_int;
  logic empty_int;
  logic wr_accept;
  logic pop;

  // -------------------------------------------------------------------------
  // Status and handshake decisions, all taken from registered state so there
  // is no combinational path from the store port to the launch outputs.
  // -------------------------------------------------------------------------
  always_comb begin
    full_int  = (count_q == CNT_W'(DEPTH));
    empty_int = (count_q == '0);

    // Fullness is judged on the pre-edge count: a store into a full FIFO is
    // rejected even if the drain pops an entry on the same edge.
    wr_accept = wr_en && !full_int;

    // A byte leaves the FIFO only from IDLE with the serialiser free.
    pop = (state_q == ST_IDLE) && !empty_int && !tx_busy;
  end

  // -------------------------------------------------------------------------
  // Pointer, occupancy and overflow next-state
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A new overflow event takes priority over a clear in the same cycle so
    // that software never misses a loss that raced with its acknowledge.
    overflow_d = overflow_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (wr_en && full_int) begin
      overflow_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Drain controller next-state
  //   IDLE       pop a byte into tx_data and raise tx_start
  //   LAUNCH     drop tx_start after exactly one cycle
  //   WAIT_BUSY  wait for uart_tx to acknowledge by raising tx_busy; a frame
  //              short enough to finish before busy is seen ends on tx_done
  //   WAIT_DONE  wait for the frame to end
  // tx_start defaults low, so it can only be high for the single cycle that
  // follows an IDLE pop and the LAUNCH state guarantees a gap after it.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_data_d  = mem[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        state_d = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tx_done) begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_DONE: begin
        if (tx_done || !tx_busy) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control and launch registers. Reset abandons any frame in flight: the
  // FIFO is emptied and the controller returns to IDLE, so nothing is
  // launched again until a fresh byte is stored.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign full     = full_int;
  assign empty    = empty_int;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. A small behavioural uart_tx stand-in
// answers every tx_start with FRAME cycles of tx_busy followed by a tx_done
// pulse, and records each launched byte with the cycle it was launched in.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int FRAME  = 8;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              wr_en     = 1'b0;
  logic [DATA_W-1:0] wr_data   = '0;
  logic              ovf_clr   = 1'b0;
  logic              hold_busy = 1'b0;
  logic              m_busy    = 1'b0;
  logic              m_done    = 1'b0;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [4:0]        count;
  logic              full;
  logic              empty;
  logic              overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int m_cnt = 0;
  int n_starts = 0;
  int proto_err = 0;
  int consec_err = 0;
  int max_count = 0;
  logic prev_start = 1'b0;
  logic [DATA_W-1:0] sent_q[$];
  int start_cyc[$];

  assign tx_busy = m_busy | hold_busy;
  assign tx_done = m_done;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in and launch monitor, sampled 1 ns after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_cnt = 0;
        prev_start = 1'b0;
      end else begin
        if (tx_start === 1'b1 && tx_busy === 1'b1) proto_err++;
        if (tx_start === 1'b1 && prev_start) consec_err++;
        m_done = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
        if (tx_start === 1'b1) begin
          sent_q.push_back(tx_data);
          start_cyc.push_back(cyc);
          n_starts++;
          m_busy = 1'b1;
          m_cnt = FRAME;
        end
        prev_start = tx_start;
        if (int'(count) > max_count) max_count = int'(count);
      end
    end
  end

  task automatic push(input logic [DATA_W-1:0] b);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
  endtask

  task automatic end_wr();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #2;
      if (empty && !tx_busy && !tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL drain_timeout: got not drained, want drained within 3000 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL por_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL por_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL por_full: got %b want 0", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL por_overflow: got %b want 0", overflow); end
    n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL por_tx_start: got %b want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL por_tx_data: got %h want 00", tx_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    bit got;
    int s;
    sent_q.delete(); start_cyc.delete();
    push(8'h41);
    push(8'h42);
    end_wr();
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (tx_start === 1'b1) begin got = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL mid_start_timeout: got no tx_start, want one within 20 cycles"); end
    n_cmp++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL mid_tx_data: got %h want 41", tx_data); end
    // Well inside the frame: controller is in WAIT_DONE, 0x42 still queued
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL mid_count_pre: got %0d want 1", count); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL mid_rst_full: got %b want 0", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_overflow: got %b want 0", overflow); end
    n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx_start: got %b want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_tx_data: got %h want 00", tx_data); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s = n_starts;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++; if (n_starts !== s) begin n_err++; $display("FAIL mid_no_relaunch: got %0d starts want %0d", n_starts, s); end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL mid_post_count: got %0d want 0", count); end
  endtask

  task automatic test_single();
    sent_q.delete(); start_cyc.delete();
    push(8'h55);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL single_count1: got %0d want 1", count); end
    n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_start_early: got %b want 0", tx_start); end
    @(posedge clk);
    #1;
    n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b want 1", tx_start); end
    n_cmp++; if (tx_data !== 8'h55) begin n_err++; $display("FAIL single_data: got %h want 55", tx_data); end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL single_count0: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b want 1", empty); end
    @(posedge clk);
    #1;
    n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_start_width: got %b want 0", tx_start); end
    wait_drain();
    n_cmp++; if (sent_q.size() !== 1) begin n_err++; $display("FAIL single_nsent: got %0d want 1", sent_q.size()); end
    else begin
      n_cmp++; if (sent_q[0] !== 8'h55) begin n_err++; $display("FAIL single_sent: got %h want 55", sent_q[0]); end
    end
  endtask

  task automatic test_burst();
    logic [DATA_W-1:0] exp_b [5];
    exp_b = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    sent_q.delete(); start_cyc.delete();
    for (int i = 0; i < 5; i++) push(exp_b[i]);
    end_wr();
    wait_drain();
    n_cmp++; if (sent_q.size() !== 5) begin n_err++; $display("FAIL burst_nsent: got %0d want 5", sent_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++; if (sent_q[i] !== exp_b[i]) begin n_err++; $display("FAIL burst_byte%0d: got %h want %h", i, sent_q[i], exp_b[i]); end
      end
      // busy falls FRAME cycles after a launch; IDLE is re-entered one edge
      // later and the next pop happens on the edge after that
      for (int i = 1; i < 5; i++) begin
        n_cmp++;
        if (start_cyc[i] - start_cyc[i-1] !== FRAME + 2) begin
          n_err++;
          $display("FAIL burst_gap%0d: got %0d cycles want %0d", i, start_cyc[i] - start_cyc[i-1], FRAME + 2);
        end
      end
    end
    n_cmp++; if (proto_err !== 0) begin n_err++; $display("FAIL burst_start_while_busy: got %0d want 0", proto_err); end
    n_cmp++; if (consec_err !== 0) begin n_err++; $display("FAIL burst_consec_start: got %0d want 0", consec_err); end
  endtask

  task automatic test_overflow();
    int s;
    sent_q.delete(); start_cyc.delete();
    @(negedge clk);
    hold_busy = 1'b1;
    s = n_starts;
    for (int i = 0; i < 16; i++) push(8'(i));
    @(posedge clk);
    #1;
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count16: got %0d want 16", count); end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", overflow); end
    push(8'h10);
    @(posedge clk);
    #1;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count_hold: got %0d want 16", count); end
    n_cmp++; if (n_starts !== s) begin n_err++; $display("FAIL ovf_launch_while_busy: got %0d starts want %0d", n_starts, s); end
    end_wr();
    @(negedge clk);
    hold_busy = 1'b0;
    wait_drain();
    n_cmp++; if (sent_q.size() !== 16) begin n_err++; $display("FAIL ovf_nsent: got %0d want 16", sent_q.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++; if (sent_q[i] !== 8'(i)) begin n_err++; $display("FAIL ovf_byte%0d: got %h want %h", i, sent_q[i], 8'(i)); end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] exp_q[$];
    int g;
    int guard;
    sent_q.delete(); start_cyc.delete();
    max_count = 0;
    for (int i = 0; i < 40; i++) begin
      g = $urandom_range(0, 3);
      @(negedge clk);
      wr_en = 1'b0;
      repeat (g) @(negedge clk);
      guard = 0;
      while (full && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      wr_en = 1'b1;
      wr_data = 8'(i * 37 + 5);
      exp_q.push_back(8'(i * 37 + 5));
    end
    end_wr();
    wait_drain();
    n_cmp++; if (sent_q.size() !== 40) begin n_err++; $display("FAIL wrap_nsent: got %0d want 40", sent_q.size()); end
    else begin
      for (int i = 0; i < 40; i++) begin
        n_cmp++; if (sent_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_byte%0d: got %h want %h", i, sent_q[i], exp_q[i]); end
      end
    end
    n_cmp++; if (max_count > 16) begin n_err++; $display("FAIL wrap_max_count: got %0d want <= 16", max_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_overflow: got %b want 0", overflow); end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL wrap_count_end: got %0d want 0", count); end
    n_cmp++; if (consec_err !== 0) begin n_err++; $display("FAIL wrap_consec_start: got %0d want 0", consec_err); end
  endtask

  task automatic test_simultaneous();
    sent_q.delete(); start_cyc.delete();
    @(negedge clk);
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'hB0 + 8'(i));
    @(negedge clk);
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL sim_full: got %b want 1", full); end
    // pop and rejected store on the same edge
    hold_busy = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    @(posedge clk);
    #1;
    n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL sim_count15: got %0d want 15", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sim_overflow: got %b want 1", overflow); end
    n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL sim_pop_start: got %b want 1", tx_start); end
    n_cmp++; if (tx_data !== 8'hB0) begin n_err++; $display("FAIL sim_pop_data: got %h want b0", tx_data); end
    // accepted store while clearing: clear takes effect
    @(negedge clk);
    wr_data = 8'hC0;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sim_clear: got %b want 0", overflow); end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL sim_refill: got %0d want 16", count); end
    // rejected store while clearing: set wins
    @(negedge clk);
    wr_data = 8'hC1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sim_set_wins: got %b want 1", overflow); end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL sim_count_full: got %0d want 16", count); end
    @(negedge clk);
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    wait_drain();
    n_cmp++; if (sent_q.size() !== 17) begin n_err++; $display("FAIL sim_nsent: got %0d want 17", sent_q.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++; if (sent_q[i] !== 8'hB0 + 8'(i)) begin n_err++; $display("FAIL sim_byte%0d: got %h want %h", i, sent_q[i], 8'hB0 + 8'(i)); end
      end
      n_cmp++; if (sent_q[16] !== 8'hC0) begin n_err++; $display("FAIL sim_byte16: got %h want c0", sent_q[16]); end
    end
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sim_final_clear: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
